f32_operand_loader: RTL

Byte-serial front end for the single-precision adder/subtractor stage. Collects operand A, operand B and the operation select as nine bytes over a valid/ready byte port, and drives them as stable words into the combinational adder. After a fixed settle interval it captures the adder's result and flags into a held result register with its own valid/ready handshake. It sits directly upstream of the adder, between the board input logic and the combinational datapath.

---
 rtl/f32_operand_loader_pkg.sv | 33 +++
 rtl/f32_operand_loader_if.sv | 34 +++
 rtl/f32_byte_shifter.sv | 32 +++
 rtl/f32_operand_loader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/f32_operand_loader_pkg.sv
// -----------------------------------------------------------------------------
// f32_io_pkg
// Shared types and constants for the byte-serial operand loader that feeds the
// single-precision adder/subtractor.
//   - state_e        : loader FSM states
//   - BYTES_PER_WORD : bytes that make up one operand word
//   - F32_*_W        : IEEE-754 single-precision field widths
//   - is_last_byte() : true when the byte counter sits on the final byte slot
// -----------------------------------------------------------------------------
package f32_io_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_OP,
        SETTLE,
        HOLD
    } state_e;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    localparam int F32_SIGN_W = 1;
    localparam int F32_EXP_W  = 8;
    localparam int F32_MAN_W  = 23;
    localparam int F32_W      = F32_SIGN_W + F32_EXP_W + F32_MAN_W;

    // Byte counter width is fixed at 2 bits; the last slot is BYTES_PER_WORD-1.
    function automatic logic is_last_byte(input logic [1:0] cnt);
        return cnt == 2'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/f32_operand_loader_if.sv
// -----------------------------------------------------------------------------
// f32_operand_loader_if
// Bundles the two handshaked channels of the operand loader:
//   byte input : din[7:0], din_valid (upstream -> loader), din_ready (loader -> upstream)
//   result     : res[31:0], res_uf, res_of, res_valid (loader -> consumer),
//                res_ready (consumer -> loader)
// Modports:
//   master : the upstream byte source plus the result consumer
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface f32_operand_loader_if;
    import f32_io_pkg::*;

    logic [BYTE_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    logic [F32_W-1:0]  res;
    logic              res_uf;
    logic              res_of;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output din, din_valid, res_ready,
        input  din_ready, res, res_uf, res_of, res_valid
    );

    modport slave (
        input  din, din_valid, res_ready,
        output din_ready, res, res_uf, res_of, res_valid
    );

endinterface

// File: rtl/f32_byte_shifter.sv
// -----------------------------------------------------------------------------
// f32_byte_shifter
// 32-bit big-endian shift-in register. Each enabled cycle shifts the word left
// by one byte and inserts din at the bottom, so the first byte of a word ends
// up in bits 31:24 after four shifts.
// Ports:
//   clk  in  1   rising-edge clock
//   clr  in  1   synchronous clear (wins over en)
//   en   in  1   shift din in this cycle
//   din  in  8   byte to insert
//   q    out 32  assembled word
// -----------------------------------------------------------------------------
module f32_byte_shifter
    import f32_io_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] din,
    output logic [F32_W-1:0]  q
);

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[F32_W-BYTE_W-1:0], din};
        end
    end

endmodule

// File: rtl/f32_operand_loader.sv
// -----------------------------------------------------------------------------
// f32_operand_loader
// Byte-serial front end for the combinational f32 adder/subtractor. Collects
// operand A (4 bytes), operand B (4 bytes) and an op byte, holds them stable on
// opa/opb/opsel, waits SETTLE_CYCLES for the adder to settle, then captures the
// adder result and flags into a held result register with its own handshake.
// Parameters:
//   SETTLE_CYCLES  cycles from op-byte acceptance to result capture (1..15)
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   synchronous active-low reset
//   bus            slave    byte input channel and result channel
//   opa, opb       out  32  operands to the adder (change only on accepted bytes)
//   opsel          out  1   0 = add, 1 = subtract
//   add_r          in   32  adder result
//   add_underflow  in   1   adder underflow flag
//   add_overflow   in   1   adder overflow flag
//   busy           out  1   a transaction is in progress
// -----------------------------------------------------------------------------
module f32_operand_loader
    import f32_io_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    f32_operand_loader_if.slave  bus,
    output logic [F32_W-1:0]     opa,
    output logic [F32_W-1:0]     opb,
    output logic                 opsel,
    input  logic [F32_W-1:0]     add_r,
    input  logic                 add_underflow,
    input  logic                 add_overflow,
    output logic                 busy
);

    // Counter is preloaded with SETTLE_CYCLES-1 so capture lands exactly
    // SETTLE_CYCLES edges after the op byte is accepted.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;

    logic        accept;
    logic        shift_a;
    logic        shift_b;
    logic        load_op;
    logic        capture;
    logic        release_res;
    logic        clr;

    // din_ready is a register, so a byte handshake never depends
    // combinationally on din_valid.
    assign accept = bus.din_valid && bus.din_ready;
    assign clr    = !rst_n;

    // -------------------------------------------------------------------------
    // Operand shift registers
    // -------------------------------------------------------------------------
    f32_byte_shifter u_shift_a (
        .clk (clk),
        .clr (clr),
        .en  (shift_a),
        .din (bus.din),
        .q   (opa)
    );

    f32_byte_shifter u_shift_b (
        .clk (clk),
        .clr (clr),
        .en  (shift_b),
        .din (bus.din),
        .q   (opb)
    );

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        settle_cnt_d = settle_cnt_q;
        shift_a      = 1'b0;
        shift_b      = 1'b0;
        load_op      = 1'b0;
        capture      = 1'b0;
        release_res  = 1'b0;

        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    shift_a    = 1'b1;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (is_last_byte(byte_cnt_q)) begin
                        state_d = LOAD_B;
                    end
                end
            end

            LOAD_B: begin
                if (accept) begin
                    shift_b    = 1'b1;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (is_last_byte(byte_cnt_q)) begin
                        state_d = LOAD_OP;
                    end
                end
            end

            LOAD_OP: begin
                if (accept) begin
                    load_op      = 1'b1;
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = SETTLE;
                end
            end

            SETTLE: begin
                if (settle_cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end

            HOLD: begin
                if (bus.res_ready) begin
                    release_res = 1'b1;
                    state_d     = LOAD_A;
                end
            end

            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, op select, result register and handshake flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= LOAD_A;
            byte_cnt_q    <= 2'd0;
            settle_cnt_q  <= 4'd0;
            opsel         <= 1'b0;
            bus.res       <= '0;
            bus.res_uf    <= 1'b0;
            bus.res_of    <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.din_ready <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            settle_cnt_q <= settle_cnt_d;

            // Only bit 0 of the op byte is meaningful.
            if (load_op) begin
                opsel <= bus.din[0];
            end

            if (capture) begin
                bus.res       <= add_r;
                bus.res_uf    <= add_underflow;
                bus.res_of    <= add_overflow;
                bus.res_valid <= 1'b1;
            end else if (release_res) begin
                bus.res_valid <= 1'b0;
            end

            // Registered from the next state so it is 0 through the reset
            // cycle and rises on the first edge after reset is released.
            bus.din_ready <= (state_d == LOAD_A) || (state_d == LOAD_B) ||
                             (state_d == LOAD_OP);
        end
    end

    assign busy = !((state_q == LOAD_A) && (byte_cnt_q == 2'd0));

endmodule
